// File: rtl/sys_defs.sv
// Shared memory-bus definitions: bus commands, tag typedef, tag ownership and the tag-table entry.
package sys_defs;
    localparam int XLEN         = 32;
    localparam int NUM_MEM_TAGS = 15;

    typedef logic [3:0] MEM_TAG;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } MEM_COMMAND;

    typedef enum logic {
        OWN_ICACHE = 1'b0,
        OWN_DCACHE = 1'b1
    } MEM_OWNER;

    typedef struct packed {
        logic     valid;
        MEM_OWNER owner;
        logic     squashed;
    } MEM_TAG_ENTRY;
endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-tag ownership table: per-tag {valid, owner, squashed}, completion lookup,
// and a registered count of live icache-owned tags.
module mem_tag_table
    import sys_defs::*;
#(
    parameter int NUM_TAGS = NUM_MEM_TAGS,
    parameter int TAG_W    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set_en_i,
    input  logic [TAG_W-1:0] set_tag_i,
    input  MEM_OWNER         set_owner_i,
    input  logic [TAG_W-1:0] clr_tag_i,
    input  logic             squash_i,
    output MEM_TAG_ENTRY     hit_o,
    output logic [TAG_W-1:0] icache_count_o
);
    MEM_TAG_ENTRY     entries_q [1:NUM_TAGS];
    MEM_TAG_ENTRY     entries_d [1:NUM_TAGS];
    logic [TAG_W-1:0] cnt_q, cnt_d;

    // Tag 0 never matches, so a null completion yields an invalid hit.
    always_comb begin
        hit_o = '0;
        for (int i = 1; i <= NUM_TAGS; i++)
            if (clr_tag_i == TAG_W'(i)) hit_o = entries_q[i];
    end

    // Clear, then squash, then set: a same-cycle accept lands unsquashed with its new owner.
    always_comb begin
        cnt_d = '0;
        for (int i = 1; i <= NUM_TAGS; i++) begin
            entries_d[i] = entries_q[i];
            if (clr_tag_i == TAG_W'(i))
                entries_d[i] = '0;
            if (squash_i && entries_d[i].valid && entries_d[i].owner == OWN_ICACHE)
                entries_d[i].squashed = 1'b1;
            if (set_en_i && set_tag_i == TAG_W'(i)) begin
                entries_d[i].valid    = 1'b1;
                entries_d[i].owner    = set_owner_i;
                entries_d[i].squashed = 1'b0;
            end
            if (entries_d[i].valid && entries_d[i].owner == OWN_ICACHE)
                cnt_d = cnt_d + TAG_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i <= NUM_TAGS; i++) entries_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 1; i <= NUM_TAGS; i++) entries_q[i] <= entries_d[i];
            cnt_q <= cnt_d;
        end
    end

    assign icache_count_o = cnt_q;
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache onto the tagged memory port and routes tagged returns to their owner.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin conflict resolution; otherwise dcache always wins.
module mem_arbiter
    import sys_defs::*;
#(
    parameter int NUM_TAGS = NUM_MEM_TAGS,
    parameter int TAG_W    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             icache_req_valid,
    input  logic [XLEN-1:0]  icache_req_addr,
    output logic             icache_req_ack,
    output logic [TAG_W-1:0] icache_req_tag,
    input  logic             icache_flush,
    output logic             icache_resp_valid,
    output logic [TAG_W-1:0] icache_resp_tag,
    output logic [63:0]      icache_resp_data,
    output logic [TAG_W-1:0] icache_outstanding,
    input  logic             dcache_req_valid,
    input  MEM_COMMAND       dcache_req_cmd,
    input  logic [XLEN-1:0]  dcache_req_addr,
    input  logic [63:0]      dcache_req_data,
    output logic             dcache_req_ack,
    output logic [TAG_W-1:0] dcache_req_tag,
    output logic             dcache_resp_valid,
    output logic [TAG_W-1:0] dcache_resp_tag,
    output logic [63:0]      dcache_resp_data,
    output MEM_COMMAND       proc2mem_command,
    output logic [XLEN-1:0]  proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    input  logic [TAG_W-1:0] mem2proc_response,
    input  logic [63:0]      mem2proc_data,
    input  logic [TAG_W-1:0] mem2proc_tag
);
    logic         gnt_i, gnt_d, prefer_d, accept, deliver;
    MEM_TAG_ENTRY hit;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    MEM_OWNER last_grant_q, last_grant_d;

    assign prefer_d = (last_grant_q == OWN_ICACHE);

    // Rejected attempts leave the pointer alone so the same side retries first.
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) last_grant_d = gnt_d ? OWN_DCACHE : OWN_ICACHE;
    end

    always_ff @(posedge clock) begin
        if (reset) last_grant_q <= OWN_ICACHE;
        else       last_grant_q <= last_grant_d;
    end
`else
    assign prefer_d = 1'b1;
`endif

    assign gnt_d  = dcache_req_valid && (!icache_req_valid || prefer_d);
    assign gnt_i  = icache_req_valid && !gnt_d;
    assign accept = (gnt_i || gnt_d) && (mem2proc_response != '0);

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (gnt_d) begin
            proc2mem_command = dcache_req_cmd;
            proc2mem_addr    = dcache_req_addr;
            proc2mem_data    = dcache_req_data;
        end else if (gnt_i) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = icache_req_addr;
        end
    end

    assign icache_req_ack = gnt_i && accept;
    assign dcache_req_ack = gnt_d && accept;
    assign icache_req_tag = icache_req_ack ? mem2proc_response : '0;
    assign dcache_req_tag = dcache_req_ack ? mem2proc_response : '0;

    // Stores never complete by tag, so only loads claim a table entry.
    mem_tag_table #(
        .NUM_TAGS(NUM_TAGS),
        .TAG_W   (TAG_W)
    ) u_tags (
        .clock         (clock),
        .reset         (reset),
        .set_en_i      (accept && (gnt_i || dcache_req_cmd == BUS_LOAD)),
        .set_tag_i     (mem2proc_response),
        .set_owner_i   (gnt_d ? OWN_DCACHE : OWN_ICACHE),
        .clr_tag_i     (mem2proc_tag),
        .squash_i      (icache_flush),
        .hit_o         (hit),
        .icache_count_o(icache_outstanding)
    );

    assign deliver           = hit.valid && !hit.squashed;
    assign icache_resp_valid = deliver && hit.owner == OWN_ICACHE;
    assign dcache_resp_valid = deliver && hit.owner == OWN_DCACHE;
    assign icache_resp_tag   = icache_resp_valid ? mem2proc_tag  : '0;
    assign icache_resp_data  = icache_resp_valid ? mem2proc_data : '0;
    assign dcache_resp_tag   = dcache_resp_valid ? mem2proc_tag  : '0;
    assign dcache_resp_data  = dcache_resp_valid ? mem2proc_data : '0;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single tagged main-memory port between the instruction cache (load-only line fetches feeding fetch) and the data cache (loads and stores). It arbitrates each cycle, passes the winner to memory, and records which requester owns each outstanding memory tag. It routes tagged data returns back to that owner. It also supports an instruction-side flush so that refills in flight at a fetch redirect are discarded rather than delivered.

## Interface
Parameters:
- NUM_TAGS, 15: number of non-zero memory tags; tag 0 means "none/rejected".
- TAG_W, 4: tag width; must satisfy 2^TAG_W > NUM_TAGS.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- icache_req_valid  in  1  icache line-load request pending
- icache_req_addr  in  XLEN  line address, bits [2:0] zero
- icache_req_ack  out  1  request accepted by memory this cycle
- icache_req_tag  out  TAG_W  tag assigned on ack (0 otherwise)
- icache_flush  in  1  squash all icache-owned outstanding loads
- icache_resp_valid  out  1  refill data for icache this cycle
- icache_resp_tag  out  TAG_W  tag of delivered refill
- icache_resp_data  out  64  refill line
- icache_outstanding  out  TAG_W  count of live (unsquashed or squashed) icache tags
- dcache_req_valid  in  1  dcache request pending
- dcache_req_cmd  in  MEM_COMMAND  BUS_LOAD or BUS_STORE
- dcache_req_addr  in  XLEN  line address
- dcache_req_data  in  64  store data
- dcache_req_ack / dcache_req_tag / dcache_resp_valid / dcache_resp_tag / dcache_resp_data: as icache equivalents
- proc2mem_command  out  MEM_COMMAND  BUS_NONE/BUS_LOAD/BUS_STORE
- proc2mem_addr  out  XLEN
- proc2mem_data  out  64
- mem2proc_response  in  TAG_W  accept tag, 0 = rejected
- mem2proc_data  in  64
- mem2proc_tag  in  TAG_W  completing tag, 0 = none

## Operation
- Grant (combinational): only one valid requester wins. If both are valid, the winner follows the policy in Configuration. No requester valid: proc2mem_command = BUS_NONE, addr/data = 0.
- Winner's cmd/addr/data are driven to memory in the same cycle. Icache always issues BUS_LOAD.
- Accept: winner ack = (mem2proc_response != 0), and req_tag = mem2proc_response. Loser ack = 0. Requesters hold their request until acked.
- Tag table (registered, NUM_TAGS entries): {valid, owner, squashed}. Accepted load: the entry is set valid with owner = winner and squashed = 0. Accepted store: no entry is created, because stores never complete by tag.
- Completion: mem2proc_tag != 0 with a valid entry. If the entry is not squashed, assert the owner's resp_valid with tag/data passed through. Then clear the entry. Completion on an invalid entry is dropped silently.
- icache_flush: every valid icache-owned entry has squashed set at the edge. Their returns clear the entry but produce no resp_valid. Dcache entries are unaffected. A load accepted in the same cycle as the flush is not squashed.
- Same-cycle completion and accept of the same tag: the clear applies first, then the set. The entry ends up valid with the new owner.
- icache_outstanding = number of valid icache-owned entries, registered.

## Timing
- Request to ack: 0 cycles (combinational through memory's response).
- Return to resp_valid: 0 cycles. This is a lookup into a registered table.
- Table, squash bits, counter, and policy state update on posedge clock.
- Reset: all entries invalid, icache_outstanding = 0, policy pointer = last-granted icache. All outputs are 0/BUS_NONE while no requests are valid.
- Reset mid-operation discards all ownership. Any later return of a pre-reset tag is dropped.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: a 1-bit last_grant register. On conflict, grant the requester not granted last. last_grant updates only on an accepted transfer; rejection leaves it unchanged.
- Undefined: fixed priority, with dcache always winning a conflict. No last_grant register.

## Structure
- Shared sys_defs package: MEM_COMMAND enum (BUS_NONE, BUS_LOAD, BUS_STORE), NUM_MEM_TAGS, MEM_TAG typedef, MEM_OWNER enum {OWN_ICACHE, OWN_DCACHE}, and the tag-entry struct.
- Sub-module mem_tag_table: entry array with set/clear/squash ports, owner lookup, and the icache count. mem_arbiter holds grant logic and muxing.

## Test plan
- Icache only: addr 0x100, response 3 → icache_req_ack=1, tag 3. Two cycles later, mem2proc_tag=3 with data 0xDEADBEEF_CAFEF00D → icache_resp_valid=1 with that data, and dcache_resp_valid=0.
- Both valid, fixed priority: dcache load 0x200, icache 0x100, response 5 → proc2mem_addr=0x200, dcache ack with tag 5, icache_req_ack=0.
- Round robin (macro on): both held for 4 cycles, responses 1,2,3,4 → grants D,I,D,I. Then response 0 on cycle 5 → no ack, and the next grant is still D.
- Dcache store tag 6 → ack. A later mem2proc_tag=6 produces no resp on either side.
- Icache tags 2 and 5 outstanding, then flush, then returns on 2 and 5 → no icache_resp_valid, and icache_outstanding steps 2→1→0.
- Tag 7 outstanding, then reset, then mem2proc_tag=7 → no resp. Separately, return of tag 4 in the same cycle as a new accept of tag 4 → data is delivered to the old owner and the entry ends up valid for the new owner.
